// File: rtl/path_meter_pkg.sv
// Shared FSM state encoding and default parameter values for the path delay meter.
package path_meter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RISE,
      ST_HOLD,
      ST_FALL,
      ST_RESULT
   } meterState_e;

   localparam int DEF_CNT_W       = 8;
   localparam int DEF_SETTLE_CYC  = 16;
   localparam int DEF_TIMEOUT_CYC = 200;
   localparam bit DEF_PATH_INVERT = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages clear on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/path_delay_meter.sv
// Measures the rise and fall propagation delay of an external path in clock cycles,
// driving launch_o and watching the synchronized capture_i for the matching level.
module path_delay_meter
   import path_meter_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter bit PATH_INVERT = DEF_PATH_INVERT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             launch_o,
   input  logic             capture_i,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] rise_dly,
   output logic [CNT_W-1:0] fall_dly,
   output logic             timeout,
   output logic             init_err
);

   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

   meterState_e      state_q;
   logic [CNT_W-1:0] edgeCnt_q;
   logic [CNT_W-1:0] edgeCnt_d;
   logic [SET_W-1:0] settleCnt_q;
   logic [SET_W-1:0] settleCnt_d;
   logic             launch_q;
   logic             busy_q;
   logic             resValid_q;
   logic             timeout_q;
   logic             initErr_q;
   logic [CNT_W-1:0] riseDly_q;
   logic [CNT_W-1:0] fallDly_q;

   logic capS;
   logic capMatch;
   logic edgeTimeout;
   logic settleDone;

   sync_2ff uCapSync (
      .clk (clk),
      .rst (rst),
      .d_i (capture_i),
      .q_o (capS)
   );

   // The path has settled when its synchronized output equals the launch level
   // seen through the expected end-to-end polarity; INIT relies on launch_q being 0.
   always_comb begin
      capMatch    = (capS == (launch_q ^ PATH_INVERT));
      edgeTimeout = (edgeCnt_q == TIMEOUT_VAL);
      settleDone  = (settleCnt_q == SETTLE_LAST);
      edgeCnt_d   = (edgeCnt_q == {CNT_W{1'b1}}) ? edgeCnt_q : edgeCnt_q + 1'b1;
      settleCnt_d = settleCnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         edgeCnt_q   <= '0;
         settleCnt_q <= '0;
         launch_q    <= 1'b0;
         busy_q      <= 1'b0;
         resValid_q  <= 1'b0;
         timeout_q   <= 1'b0;
         initErr_q   <= 1'b0;
         riseDly_q   <= '0;
         fallDly_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_INIT;
                  busy_q      <= 1'b1;
                  launch_q    <= 1'b0;
                  settleCnt_q <= '0;
                  timeout_q   <= 1'b0;
                  initErr_q   <= 1'b0;
                  riseDly_q   <= '0;
                  fallDly_q   <= '0;
               end
            end
            ST_INIT: begin
               if (!settleDone) begin
                  settleCnt_q <= settleCnt_d;
               end else if (!capMatch) begin
                  initErr_q  <= 1'b1;
                  resValid_q <= 1'b1;
                  state_q    <= ST_RESULT;
               end else begin
                  launch_q  <= 1'b1;
                  edgeCnt_q <= '0;
                  state_q   <= ST_RISE;
               end
            end
            // A rise timeout abandons the fall edge and drops launch back to idle level.
            ST_RISE: begin
               if (capMatch) begin
                  riseDly_q   <= edgeCnt_q;
                  settleCnt_q <= '0;
                  state_q     <= ST_HOLD;
               end else if (edgeTimeout) begin
                  riseDly_q  <= TIMEOUT_VAL;
                  fallDly_q  <= '0;
                  timeout_q  <= 1'b1;
                  launch_q   <= 1'b0;
                  resValid_q <= 1'b1;
                  state_q    <= ST_RESULT;
               end else begin
                  edgeCnt_q <= edgeCnt_d;
               end
            end
            ST_HOLD: begin
               if (!settleDone) begin
                  settleCnt_q <= settleCnt_d;
               end else begin
                  launch_q  <= 1'b0;
                  edgeCnt_q <= '0;
                  state_q   <= ST_FALL;
               end
            end
            ST_FALL: begin
               if (capMatch) begin
                  fallDly_q  <= edgeCnt_q;
                  resValid_q <= 1'b1;
                  state_q    <= ST_RESULT;
               end else if (edgeTimeout) begin
                  fallDly_q  <= TIMEOUT_VAL;
                  timeout_q  <= 1'b1;
                  resValid_q <= 1'b1;
                  state_q    <= ST_RESULT;
               end else begin
                  edgeCnt_q <= edgeCnt_d;
               end
            end
            ST_RESULT: begin
               if (res_ready) begin
                  resValid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign launch_o  = launch_q;
   assign res_valid = resValid_q;
   assign rise_dly  = riseDly_q;
   assign fall_dly  = fallDly_q;
   assign timeout   = timeout_q;
   assign init_err  = initErr_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// Bench for path_delay_meter: a behavioural path model drives capture_i, stimulus pushes
// expected results into a scoreboard, and a monitor checks each accepted result.
module tb_path_delay_meter;

   localparam int CNT_W       = 8;
   localparam int SETTLE_CYC  = 16;
   localparam int TIMEOUT_CYC = 200;

   localparam int MODE_DELAYED = 0;
   localparam int MODE_STUCK0  = 1;
   localparam int MODE_STUCK1  = 2;

   typedef struct packed {
      logic [CNT_W-1:0] riseDly;
      logic [CNT_W-1:0] fallDly;
      logic             timeoutF;
      logic             initErr;
   } expRes_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy;
   logic             launch;
   logic             capture;
   logic             resValid;
   logic             resReady;
   logic [CNT_W-1:0] riseDly;
   logic [CNT_W-1:0] fallDly;
   logic             timeoutO;
   logic             initErrO;

   int      nChecks = 0;
   int      nErrors = 0;
   expRes_t expQ[$];

   int          pathMode  = MODE_DELAYED;
   int          riseExtra = 0;
   int          fallExtra = 0;
   logic [31:0] histQ     = '0;
   logic [32:0] taps;
   logic        tapR;
   logic        tapF;

   always #5 clk = ~clk;

   path_delay_meter #(
      .CNT_W       (CNT_W),
      .SETTLE_CYC  (SETTLE_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .PATH_INVERT (1'b0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .launch_o  (launch),
      .capture_i (capture),
      .res_valid (resValid),
      .res_ready (resReady),
      .rise_dly  (riseDly),
      .fall_dly  (fallDly),
      .timeout   (timeoutO),
      .init_err  (initErrO)
   );

   // Path model: taps[k] is launch delayed by k cycles. With the launch held long enough
   // between edges, OR of the two taps rises after the shorter delay and falls after the
   // longer one; AND does the reverse, giving independent rise and fall delays.
   always @(posedge clk) histQ <= {histQ[30:0], launch};

   always_comb begin
      taps = {histQ, launch};
      tapR = taps[riseExtra];
      tapF = taps[fallExtra];
      case (pathMode)
         MODE_STUCK0: capture = 1'b0;
         MODE_STUCK1: capture = 1'b1;
         default:     capture = (riseExtra <= fallExtra) ? (tapR | tapF) : (tapR & tapF);
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: the synchronizer plus the counting rule gives 2 cycles for a direct
   // loopback, plus one per cycle of path delay; stuck paths time out or fail INIT.
   function automatic expRes_t modelResult(input int mode, input int r, input int f);
      expRes_t m;
      m = '0;
      case (mode)
         MODE_STUCK0: begin
            m.riseDly  = CNT_W'(TIMEOUT_CYC);
            m.timeoutF = 1'b1;
         end
         MODE_STUCK1: m.initErr = 1'b1;
         default: begin
            m.riseDly = CNT_W'(2 + r);
            m.fallDly = CNT_W'(2 + f);
         end
      endcase
      return m;
   endfunction

   // Monitor: every accepted result must match the oldest pending expectation.
   always @(negedge clk) begin
      expRes_t e;
      if (!rst && resValid && resReady) begin
         if (expQ.size() == 0) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL unexpectedResult: got res_valid=1, expected no pending result");
         end else begin
            e = expQ.pop_front();
            checkOutput("riseDly", 32'(riseDly), 32'(e.riseDly));
            checkOutput("fallDly", 32'(fallDly), 32'(e.fallDly));
            checkOutput("timeout", 32'(timeoutO), 32'(e.timeoutF));
            checkOutput("initErr", 32'(initErrO), 32'(e.initErr));
         end
      end
   end

   // One measurement; with readyDelay > 0 the result is stalled while start is held high.
   task automatic applyStimulus(input int mode, input int r, input int f, input int readyDelay);
      expRes_t e;
      int      cyc;
      pathMode  = mode;
      riseExtra = r;
      fallExtra = f;
      e = modelResult(mode, r, f);
      expQ.push_back(e);
      resReady = (readyDelay == 0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 2;
      @(negedge clk);
      checkOutput("busyAfterStart", 32'(busy), 32'd1);
      while (!resValid && cyc < 600) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      if (!resValid) begin
         nChecks++;
         nErrors++;
         $display("[TB] FAIL resultWait: got no res_valid after %0d cycles, expected a result", cyc);
         expQ.delete();
         @(posedge clk); #1 rst = 1'b1;
         @(posedge clk); #1 rst = 1'b0;
         resReady = 1'b1;
         return;
      end
      if (mode == MODE_STUCK1)
         checkOutput("initErrLatency", 32'(cyc), 32'(SETTLE_CYC + 2));
      if (readyDelay > 0) begin
         for (int i = 0; i < readyDelay; i++) begin
            @(posedge clk); #1 start = 1'b1;
            @(negedge clk);
            checkOutput("stallOutputs",
                        32'({resValid, busy, timeoutO, initErrO, riseDly, fallDly}),
                        32'({1'b1, 1'b1, e.timeoutF, e.initErr, e.riseDly, e.fallDly}));
         end
         @(posedge clk); #1 resReady = 1'b1;
      end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      checkOutput("idleAfterAccept",
                  32'({launch, resValid, busy, riseDly, fallDly}),
                  32'({3'b000, e.riseDly, e.fallDly}));
   endtask

   // Abort a loopback measurement during RISE; no result may follow.
   task automatic applyResetAbort();
      int cyc;
      pathMode  = MODE_DELAYED;
      riseExtra = 0;
      fallExtra = 0;
      resReady  = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 0;
      while (!launch && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("reachedRise", 32'(launch), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rstAbort", 32'({launch, busy, resValid}), 32'd0);
      repeat (40) @(posedge clk);
      @(negedge clk);
      checkOutput("noResultAfterRst", 32'(resValid), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      resReady = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("resetState",
                  32'({launch, busy, resValid, timeoutO, initErrO, riseDly, fallDly}), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      applyStimulus(MODE_DELAYED, 0, 0, 0);
      applyStimulus(MODE_DELAYED, 5, 5, 0);
      applyStimulus(MODE_DELAYED, 3, 10, 0);
      applyStimulus(MODE_STUCK0, 0, 0, 0);
      applyStimulus(MODE_STUCK1, 0, 0, 0);
      applyStimulus(MODE_DELAYED, 0, 0, 20);
      applyResetAbort();
      for (int n = 0; n < 8; n++) begin
         applyStimulus(MODE_DELAYED, int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                       int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

   initial begin
      #500000;
      nErrors++;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
